mul_seq: RTL and testbench

Iterative 32-bit unsigned multiply sequencer for the execute stage. It owns one `func_unit` instance and drives it cycle by cycle through shift-and-add steps: add (`FS=0010`), shift left (`FS=1110`) and shift right (`FS=1101`). It delivers a 32-bit low product and a sticky overflow flag through a start/busy/done handshake, so the pipeline can implement multiply without a hardware multiplier.

---
 rtl/alu_pkg.sv | 17 +
 rtl/mul_seq_if.sv | 22 ++
 rtl/func_unit.sv | 27 ++
 rtl/mul_seq.sv | 134 +++++++++++++
 tb/tb_mul_seq.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared execute-stage ALU encodings and multiply sequencer states
package alu_pkg;

    localparam logic [3:0] FS_T_A  = 4'b0000;
    localparam logic [3:0] FS_A_AB = 4'b0010;
    localparam logic [3:0] FS_LSR  = 4'b1101;
    localparam logic [3:0] FS_LSL  = 4'b1110;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SHL,
        SHR,
        DONE
    } mul_state_t;

endpackage

// File: rtl/mul_seq_if.sv
// rtl/mul_seq_if.sv - start/busy/done handshake bundle for the multiply sequencer
interface mul_seq_if;

    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        ovf;

    modport master (
        output start, op_a, op_b,
        input  busy, done, product, ovf
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, product, ovf
    );

endinterface

// File: rtl/func_unit.sv
// rtl/func_unit.sv - combinational function unit: transfer, add with carry, logical shifts
module func_unit
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  fs,
    input  logic [4:0]  sh,
    output logic [31:0] f,
    output logic        c,
    output logic        z
);

    always_comb begin
        f = 32'd0;
        c = 1'b0;
        case (fs)
            FS_T_A:  f = a;
            FS_A_AB: {c, f} = {1'b0, a} + {1'b0, b};
            FS_LSR:  f = b >> sh;
            FS_LSL:  f = b << sh;
            default: f = a;
        endcase
        z = (f == 32'd0);
    end

endmodule

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative 32-bit shift-and-add multiplier driving a shared func_unit
module mul_seq
    import alu_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    mul_seq_if.slave  bus
);

    mul_state_t  state;
    mul_state_t  next_state;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [5:0]  cnt;
    logic        lost_hi;
    logic        ovf_r;
    logic [31:0] product_r;
    logic        ovf_out;

    logic [31:0] fu_a;
    logic [31:0] fu_b;
    logic [3:0]  fu_fs;
    logic [4:0]  fu_sh;
    logic [31:0] fu_f;
    logic        fu_c;
    logic        fu_z;

    func_unit u_fu (
        .a  (fu_a),
        .b  (fu_b),
        .fs (fu_fs),
        .sh (fu_sh),
        .f  (fu_f),
        .c  (fu_c),
        .z  (fu_z)
    );

    always_comb begin
        fu_a       = 32'd0;
        fu_b       = 32'd0;
        fu_fs      = FS_T_A;
        fu_sh      = 5'd0;
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (EARLY_EXIT && (bus.op_b == 32'd0))
                        next_state = DONE;
                    else
                        next_state = bus.op_b[0] ? ADD : SHL;
                end
            end
            ADD: begin
                fu_a       = acc;
                fu_b       = mcand;
                fu_fs      = FS_A_AB;
                next_state = SHL;
            end
            SHL: begin
                fu_b       = mcand;
                fu_sh      = 5'd1;
                fu_fs      = FS_LSL;
                next_state = SHR;
            end
            SHR: begin
                fu_b  = mplier;
                fu_sh = 5'd1;
                fu_fs = FS_LSR;
                // cnt still holds the pre-increment value: 31 means this is the 32nd step
                if ((EARLY_EXIT && fu_z) || (cnt == 6'd31))
                    next_state = DONE;
                else
                    next_state = fu_f[0] ? ADD : SHL;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= 32'd0;
            mplier    <= 32'd0;
            acc       <= 32'd0;
            cnt       <= 6'd0;
            lost_hi   <= 1'b0;
            ovf_r     <= 1'b0;
            product_r <= 32'd0;
            ovf_out   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand   <= bus.op_a;
                        mplier  <= bus.op_b;
                        acc     <= 32'd0;
                        cnt     <= 6'd0;
                        lost_hi <= 1'b0;
                        ovf_r   <= 1'b0;
                    end
                end
                ADD: begin
                    acc   <= fu_f;
                    // a shifted-out multiplicand bit only matters once it is actually added
                    ovf_r <= ovf_r | fu_c | lost_hi;
                end
                SHL: begin
                    mcand   <= fu_f;
                    lost_hi <= lost_hi | mcand[31];
                end
                SHR: begin
                    mplier <= fu_f;
                    cnt    <= cnt + 6'd1;
                end
                DONE: begin
                    product_r <= acc;
                    ovf_out   <= ovf_r;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.product = product_r;
    assign bus.ovf     = ovf_out;

endmodule

// File: tb/tb_mul_seq.sv
// tb/tb_mul_seq.sv - scoreboard bench for mul_seq, early-exit and full-length instances side by side
module tb_mul_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mul_seq_if bus1 ();
    mul_seq_if bus0 ();

    mul_seq #(.EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mul_seq #(.EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    typedef struct {
        logic [31:0] p;
        logic        o;
        int          lat;
    } exp_t;

    exp_t sb1[$];
    exp_t sb0[$];
    int   total = 0;
    int   bad   = 0;

    function automatic int exp_lat(input logic [31:0] b, input bit ee);
        int pop = 0;
        int k   = 0;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) begin
                pop++;
                k = i + 1;
            end
        end
        if (!ee) return 65 + pop;
        if (b == 32'd0) return 1;
        return 1 + 2 * k + pop;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit ee);
        exp_t        e;
        logic [63:0] full;
        full  = {32'd0, a} * {32'd0, b};
        e.p   = full[31:0];
        e.o   = |full[63:32];
        e.lat = exp_lat(b, ee);
        return e;
    endfunction

    // Called just after a falling edge; returns on the falling edge where the
    // result of every active instance has been checked (cycle L+1).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit use0,
                          input int restart_cyc, input string name);
        exp_t        e[2];
        bit          seen[2];
        bit          fin[2];
        bit          busy_bad[2];
        logic        d_done[2];
        logic        d_busy[2];
        logic        d_ovf[2];
        logic [31:0] d_prod[2];
        int          cyc;
        seen[1] = 1'b0; fin[1] = 1'b0; busy_bad[1] = 1'b0;
        seen[0] = !use0; fin[0] = !use0; busy_bad[0] = 1'b0;
        bus1.start = 1'b1; bus1.op_a = a; bus1.op_b = b;
        sb1.push_back(model(a, b, 1'b1));
        if (use0) begin
            bus0.start = 1'b1; bus0.op_a = a; bus0.op_b = b;
            sb0.push_back(model(a, b, 1'b0));
        end
        cyc = 0;
        while (!(fin[0] && fin[1]) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                bus1.start = 1'b0;
                bus0.start = 1'b0;
            end
            if (restart_cyc > 0 && cyc == restart_cyc) begin
                bus1.start = 1'b1; bus1.op_a = 32'hDEAD_0001; bus1.op_b = 32'h3;
                if (use0) begin
                    bus0.start = 1'b1; bus0.op_a = 32'hDEAD_0001; bus0.op_b = 32'h3;
                end
            end
            if (restart_cyc > 0 && cyc == restart_cyc + 1) begin
                bus1.start = 1'b0; bus1.op_a = a; bus1.op_b = b;
                bus0.start = 1'b0; bus0.op_a = a; bus0.op_b = b;
            end
            d_done[1] = bus1.done; d_busy[1] = bus1.busy; d_prod[1] = bus1.product; d_ovf[1] = bus1.ovf;
            d_done[0] = bus0.done; d_busy[0] = bus0.busy; d_prod[0] = bus0.product; d_ovf[0] = bus0.ovf;
            for (int j = 0; j < 2; j++) begin
                if (!seen[j]) begin
                    if (d_done[j] === 1'b1) begin
                        seen[j] = 1'b1;
                        e[j] = (j == 1) ? sb1.pop_front() : sb0.pop_front();
                        total++;
                        if (cyc !== e[j].lat) begin
                            bad++;
                            $display("FAIL %s_latency ee=%0d: got T%0d want T%0d", name, j, cyc, e[j].lat);
                        end
                    end else if (d_busy[j] !== 1'b1) begin
                        busy_bad[j] = 1'b1;
                    end
                end else if (!fin[j]) begin
                    fin[j] = 1'b1;
                    total++;
                    if (d_prod[j] !== e[j].p || d_ovf[j] !== e[j].o || d_busy[j] !== 1'b0 || d_done[j] !== 1'b0) begin
                        bad++;
                        $display("FAIL %s_result ee=%0d: got prod=%h ovf=%b busy=%b done=%b want prod=%h ovf=%b busy=0 done=0",
                                 name, j, d_prod[j], d_ovf[j], d_busy[j], d_done[j], e[j].p, e[j].o);
                    end
                    total++;
                    if (busy_bad[j]) begin
                        bad++;
                        $display("FAIL %s_busy ee=%0d: busy dropped before done, want high T1..TL", name, j);
                    end
                end
            end
        end
        if (!(fin[0] && fin[1])) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done within 300 cycles, want done", name);
            sb1.delete();
            sb0.delete();
        end
    endtask

    task automatic test_reset();
        bus1.start = 1'b0; bus1.op_a = 32'd0; bus1.op_b = 32'd0;
        bus0.start = 1'b0; bus0.op_a = 32'd0; bus0.op_b = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bus1.busy, bus1.done, bus1.ovf, bus1.product} !== 35'd0 ||
            {bus0.busy, bus0.done, bus0.ovf, bus0.product} !== 35'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%b%b done=%b%b ovf=%b%b prod=%h/%h want all zero",
                     bus1.busy, bus0.busy, bus1.done, bus0.done, bus1.ovf, bus0.ovf, bus1.product, bus0.product);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_op(32'd6, 32'd7, 1'b1, 0, "mul_6x7");
    endtask

    task automatic test_zero();
        run_op(32'd123, 32'd0, 1'b1, 0, "zero_mplier");
        run_op(32'd0, 32'd77, 1'b1, 0, "zero_mcand");
    endtask

    task automatic test_overflow();
        run_op(32'hFFFF_FFFF, 32'd2, 1'b1, 0, "ovf_lost_hi");
        run_op(32'h7FFF_FFFF, 32'd3, 1'b1, 0, "ovf_carry");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "max_len");
        run_op(32'h0001_0000, 32'h0001_0000, 1'b1, 0, "ovf_exact_2p32");
        run_op(32'h0000_FFFF, 32'h0001_0001, 1'b1, 0, "no_ovf_edge");
    endtask

    task automatic test_start_ignored();
        run_op(32'd6, 32'd7, 1'b1, 3, "start_while_busy");
    endtask

    task automatic test_reset_mid();
        bit done_seen = 1'b0;
        bus1.start = 1'b1; bus1.op_a = 32'd6; bus1.op_b = 32'd7;
        bus0.start = 1'b1; bus0.op_a = 32'd6; bus0.op_b = 32'd7;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus1.start = 1'b0;
                bus0.start = 1'b0;
            end
            if (cyc == 4) rst = 1'b1;
            if (cyc == 5) begin
                rst = 1'b0;
                total++;
                if (bus1.busy !== 1'b0 || bus1.product !== 32'd0 || bus1.ovf !== 1'b0 ||
                    bus0.busy !== 1'b0 || bus0.product !== 32'd0 || bus0.ovf !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_mid_state: got busy=%b%b prod=%h/%h ovf=%b%b want all zero",
                             bus1.busy, bus0.busy, bus1.product, bus0.product, bus1.ovf, bus0.ovf);
                end
            end
            if (bus1.done === 1'b1 || bus0.done === 1'b1) done_seen = 1'b1;
        end
        total++;
        if (done_seen !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_done: got done pulse=%b want 0", done_seen);
        end
        run_op(32'd3, 32'd5, 1'b1, 0, "after_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i < 3) ? ($urandom & 32'h0000_0FFF) : $urandom;
            run_op(a, b, 1'b1, 0, "random");
        end
    endtask

    task automatic test_back_to_back();
        run_op(32'd9, 32'd11, 1'b0, 0, "b2b_0");
        run_op(32'd1000, 32'd0, 1'b0, 0, "b2b_1");
        run_op(32'h8000_0000, 32'd1, 1'b0, 0, "b2b_2");
        run_op(32'h1234_5678, 32'h0000_8001, 1'b0, 0, "b2b_3");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_overflow();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
